rv32i_regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32I core, replacing the fixed two-read-port register block. It provides NUM_READ synchronous read ports with same-edge write-through bypass, a hardware clear sequencer so architectural registers start at zero, a per-register pending-write scoreboard for the issue stage, and the resettable program counter. It sits between decode (read addresses, scoreboard marks) and writeback (rd write, PC update).

---
 rtl/rv32i_regfile_mp_if.sv | 31 +++
 rtl/rv32i_regfile_mp.sv | 118 +++++++++++
 tb/tb_rv32i_regfile_mp.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_regfile_mp_if.sv
// rtl/rv32i_regfile_mp_if.sv - decode/writeback bus of the multi-port register file
interface rv32i_regfile_mp_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int NUM_READ = 2
);
  logic                         write_i;
  logic [REG_BITS-1:0]          rd_addr_i;
  logic [XLEN-1:0]              data_i;
  logic                         write_pc_i;
  logic [XLEN-1:0]              data_pc_i;
  logic [NUM_READ*REG_BITS-1:0] rs_addr_i;
  logic [NUM_READ*XLEN-1:0]     rs_o;
  logic [NUM_READ-1:0]          rs_busy_o;
  logic                         mark_busy_i;
  logic [REG_BITS-1:0]          busy_addr_i;
  logic [XLEN-1:0]              pc_o;
  logic                         ready_o;

  modport master (
    output write_i, rd_addr_i, data_i, write_pc_i, data_pc_i, rs_addr_i,
           mark_busy_i, busy_addr_i,
    input  rs_o, rs_busy_o, pc_o, ready_o
  );

  modport slave (
    input  write_i, rd_addr_i, data_i, write_pc_i, data_pc_i, rs_addr_i,
           mark_busy_i, busy_addr_i,
    output rs_o, rs_busy_o, pc_o, ready_o
  );
endinterface

// File: rtl/rv32i_regfile_mp.sv
// rtl/rv32i_regfile_mp.sv - multi-read-port integer register file with clear sequencer, scoreboard and PC
module rv32i_regfile_mp #(
  parameter int              XLEN         = 32,
  parameter int              REG_BITS     = 5,
  parameter int              NUM_READ     = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic              clk_i,
  input logic              rst_ni,
  rv32i_regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** REG_BITS;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                        state, state_next;
  logic [REG_BITS-1:0]           cnt, cnt_next;
  logic                          clearing;
  logic                          ready;
  logic                          eff_write;
  logic                          eff_mark;
  logic                          mem_we;
  logic [REG_BITS-1:0]           mem_waddr;
  logic [XLEN-1:0]               mem_wdata;
  logic [DEPTH-1:0]              busy, busy_next;
  logic [NUM_READ-1:0][XLEN-1:0] rs_q;
  logic [NUM_READ-1:0]           rs_busy_q;
  logic [XLEN-1:0]               pc_q;

  // Clear sequencer state and index register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Walk every index once after reset, then stay in RUN until the next reset
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clearing   = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        cnt_next = cnt + 1'b1;
        if (&cnt) state_next = RUN;
      end
      RUN: begin
        state_next = RUN;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign ready     = (state == RUN);
  assign eff_write = ready && bus.write_i && (bus.rd_addr_i != '0);
  assign eff_mark  = ready && bus.mark_busy_i && (bus.busy_addr_i != '0);

  // The clear sequencer and writeback share the single write port of each copy
  assign mem_we    = clearing || eff_write;
  assign mem_waddr = clearing ? cnt : bus.rd_addr_i;
  assign mem_wdata = clearing ? '0 : bus.data_i;

  // Scoreboard update: writeback clears, issue marks; a same-edge mark wins
  always_comb begin
    busy_next = busy;
    if (eff_write) busy_next[bus.rd_addr_i] = 1'b0;
    if (eff_mark)  busy_next[bus.busy_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy <= '0;
    else         busy <= busy_next;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [REG_BITS-1:0] addr;
    logic [XLEN-1:0]     mem [DEPTH];

    assign addr = bus.rs_addr_i[p*REG_BITS +: REG_BITS];

    // Private storage copy for this port; every copy sees every write
    always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Registered read with write-first bypass; x0 and the clear phase read as zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rs_q[p]      <= '0;
        rs_busy_q[p] <= 1'b0;
      end else if (clearing || addr == '0) begin
        rs_q[p]      <= '0;
        rs_busy_q[p] <= 1'b0;
      end else begin
        rs_q[p]      <= (eff_write && addr == bus.rd_addr_i) ? bus.data_i : mem[addr];
        rs_busy_q[p] <= busy_next[addr];
      end
    end
  end

  // Program counter; loads are honoured even while the clear runs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             pc_q <= RESET_VECTOR;
    else if (bus.write_pc_i) pc_q <= bus.data_pc_i;
  end

  assign bus.rs_o      = rs_q;
  assign bus.rs_busy_o = rs_busy_q;
  assign bus.pc_o      = pc_q;
  assign bus.ready_o   = ready;
endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// tb/tb_rv32i_regfile_mp.sv - scoreboard bench for rv32i_regfile_mp
module tb_rv32i_regfile_mp;
  logic clk;
  logic rst_n;

  rv32i_regfile_mp_if #(.XLEN(32), .REG_BITS(5), .NUM_READ(2)) bus ();

  rv32i_regfile_mp #(
    .XLEN(32), .REG_BITS(5), .NUM_READ(2), .RESET_VECTOR(32'h0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  string       cur_tag  = "init";

  logic [31:0] mdl_mem [32];
  logic [31:0] mdl_busy;
  logic        mdl_ready;
  int          mdl_cnt;
  logic [31:0] mdl_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_busy  = '0;
    mdl_ready = 1'b0;
    mdl_cnt   = 0;
    mdl_pc    = 32'h0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), push expectations, compare after the edge
  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mk, input logic [4:0] ba,
                       input logic wpc, input logic [31:0] dpc,
                       input logic [4:0] a0, input logic [4:0] a1);
    logic [4:0]  a [2];
    logic        eff;
    logic [31:0] nsb;
    exp_t        e;
    a[0] = a0;
    a[1] = a1;
    bus.write_i     = we;
    bus.rd_addr_i   = rd;
    bus.data_i      = d;
    bus.mark_busy_i = mk;
    bus.busy_addr_i = ba;
    bus.write_pc_i  = wpc;
    bus.data_pc_i   = dpc;
    bus.rs_addr_i   = {a1, a0};
    eff = mdl_ready && we && (rd != 0);
    nsb = mdl_busy;
    if (eff) nsb[rd] = 1'b0;
    if (mdl_ready && mk && ba != 0) nsb[ba] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (!mdl_ready || a[p] == 0) e = '{d: 32'h0, b: 1'b0};
      else if (eff && a[p] == rd)  e = '{d: d, b: nsb[a[p]]};
      else                         e = '{d: mdl_mem[a[p]], b: nsb[a[p]]};
      exp_q.push_back(e);
    end
    if (!mdl_ready) begin
      mdl_mem[mdl_cnt] = 32'h0;
      if (mdl_cnt == 31) mdl_ready = 1'b1;
      mdl_cnt = (mdl_cnt + 1) % 32;
    end else if (eff) begin
      mdl_mem[rd] = d;
    end
    mdl_busy = nsb;
    if (wpc) mdl_pc = dpc;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front();
      check($sformatf("%s/rs%0d", cur_tag, p), {32'h0, bus.rs_o[p*32 +: 32]}, {32'h0, e.d});
      check($sformatf("%s/busy%0d", cur_tag, p), {63'h0, bus.rs_busy_o[p]}, {63'h0, e.b});
    end
    check({cur_tag, "/ready"}, {63'h0, bus.ready_o}, {63'h0, mdl_ready});
    check({cur_tag, "/pc"}, {32'h0, bus.pc_o}, {32'h0, mdl_pc});
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, a0, a1);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] a0, input logic [4:0] a1);
    cycle(1'b1, rd, d, 1'b0, 5'd0, 1'b0, 32'h0, a0, a1);
  endtask

  // Assert reset mid-cycle (no edge in between), check the asynchronous return, hold 3 cycles, release
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.write_i = 1'b0;
    bus.mark_busy_i = 1'b0;
    bus.write_pc_i = 1'b0;
    #1;
    check({cur_tag, "/rst_rs"}, {32'h0, bus.rs_o}, 64'h0);
    check({cur_tag, "/rst_busy"}, {62'h0, bus.rs_busy_o}, 64'h0);
    check({cur_tag, "/rst_ready"}, {63'h0, bus.ready_o}, 64'h0);
    check({cur_tag, "/rst_pc"}, {32'h0, bus.pc_o}, 64'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int start_n);
    int n;
    n = start_n;
    while (!bus.ready_o && n < 100) begin
      idle(5'd0, 5'd0);
      n++;
    end
    check({cur_tag, "/clear_edges"}, 64'(n), 64'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl_mem[i] = 32'hBAD0_0000 | i;
    rst_n = 1'b1;
    bus.write_i = 1'b0;
    bus.rd_addr_i = '0;
    bus.data_i = '0;
    bus.write_pc_i = 1'b0;
    bus.data_pc_i = '0;
    bus.rs_addr_i = '0;
    bus.mark_busy_i = 1'b0;
    bus.busy_addr_i = '0;
    @(posedge clk);
    #1;

    cur_tag = "clear";
    do_reset();
    wait_ready(0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    cur_tag = "wr_x5";
    wr(5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    idle(5'd5, 5'd0);
    check("wr_x5/const", {32'h0, bus.rs_o[31:0]}, {32'h0, 32'hDEADBEEF});

    cur_tag = "wr_x0";
    wr(5'd0, 32'h1234, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    cur_tag = "bypass";
    wr(5'd6, 32'h1111_1111, 5'd0, 5'd0);
    wr(5'd7, 32'hA5A5A5A5, 5'd6, 5'd7);
    check("bypass/const", {32'h0, bus.rs_o[63:32]}, {32'h0, 32'hA5A5A5A5});

    cur_tag = "sb_mark";
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0, 5'd0, 5'd0);
    idle(5'd9, 5'd9);
    cur_tag = "sb_write";
    wr(5'd9, 32'd5, 5'd9, 5'd0);
    idle(5'd9, 5'd9);
    cur_tag = "sb_both";
    cycle(1'b1, 5'd9, 32'd7, 1'b1, 5'd9, 1'b0, 32'h0, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    check("sb_both/const", {63'h0, bus.rs_busy_o[0]}, 64'd1);
    cur_tag = "sb_x0";
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    cur_tag = "populate";
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'hC0DE_0000 + i, 5'(i), 5'(i));
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 32'h0, 5'd2, 5'd1);

    cur_tag = "midrun";
    do_reset();
    cur_tag = "clr_ignore";
    cycle(1'b1, 5'd3, 32'hFFFF, 1'b1, 5'd3, 1'b1, 32'h100, 5'd3, 5'd3);
    wait_ready(1);
    check("clr_ignore/pc", {32'h0, bus.pc_o}, {32'h0, 32'h100});
    idle(5'd3, 5'd3);
    cur_tag = "after_rst";
    for (int i = 1; i <= 4; i++) idle(5'(i), 5'(5 - i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
